// File: rtl/alu_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_rr_arbiter_pkg
// Shared definitions for the two-requester shift/ALU arbiter:
//   - default datapath widths
//   - ALU opcode constants
//   - bit positions of the {N,Z,C,V} flag vector
//   - FSM state encoding for the arbiter controller
//   - a packed flag struct and the round-robin pick helper
// ---------------------------------------------------------------------------
package alu_rr_arbiter_pkg;

    localparam int DATA_W_DEF  = 5;
    localparam int SHAMT_W_DEF = 2;
    localparam int OPC_W_DEF   = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    // Positions inside the 4-bit flag vector {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    // One-hot grant for two requesters. When both are valid the requester
    // that was NOT served last wins; otherwise the lone valid one wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] valid,
                                           input logic       last);
        logic [1:0] g;
        g = valid;
        if (valid == 2'b11) begin
            g = last ? 2'b01 : 2'b10;
        end
        return g;
    endfunction

endpackage

// File: rtl/alu_rr_arbiter_shift_alu_datapath.sv
// ---------------------------------------------------------------------------
// shift_alu_datapath
// Purely combinational pre-shift + ALU + flag generation.
//   Operand a is shifted first (left, or logical right), then combined with b.
//   Every intermediate value is truncated to DATA_W.
// Ports
//   i_a       in   DATA_W   operand a (pre-shifted)
//   i_b       in   DATA_W   operand b
//   i_op      in   OPC_W    000 add, 001 sub, 010 and, 011 or, 100 xor, else 0
//   i_sh      in   SHAMT_W  shift amount for a
//   i_dir     in   1        0 = shift left, 1 = logical shift right
//   o_result  out  DATA_W   ALU result
//   o_flags   out  4        {N,Z,C,V}
// ---------------------------------------------------------------------------
module shift_alu_datapath
    import alu_rr_arbiter_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF,
    parameter int OPC_W   = OPC_W_DEF
) (
    input  logic [DATA_W-1:0]  i_a,
    input  logic [DATA_W-1:0]  i_b,
    input  logic [OPC_W-1:0]   i_op,
    input  logic [SHAMT_W-1:0] i_sh,
    input  logic               i_dir,
    output logic [DATA_W-1:0]  o_result,
    output logic [3:0]         o_flags
);

    logic [DATA_W-1:0] w_a_sh;
    logic [DATA_W-1:0] w_b_eff;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_result;
    alu_flags_t        w_flags;

    assign w_a_sh  = i_dir ? (i_a >> i_sh) : (i_a << i_sh);

    // op[0] selects two's-complement subtract: a' + ~b + 1.
    assign w_b_eff = i_op[0] ? ~i_b : i_b;
    assign w_sum   = {1'b0, w_a_sh} + {1'b0, w_b_eff} + {{DATA_W{1'b0}}, i_op[0]};

    always_comb begin
        w_result = '0;
        case (i_op)
            OPC_W'(OP_ADD): w_result = w_sum[DATA_W-1:0];
            OPC_W'(OP_SUB): w_result = w_sum[DATA_W-1:0];
            OPC_W'(OP_AND): w_result = w_a_sh & i_b;
            OPC_W'(OP_OR):  w_result = w_a_sh | i_b;
            OPC_W'(OP_XOR): w_result = w_a_sh ^ i_b;
            default:        w_result = '0;
        endcase
    end

    // C and V are gated only by op[1], so opcodes 100/101 still report the
    // carry/overflow of the add/sub adder. Downstream relies on that.
    always_comb begin
        w_flags   = '0;
        w_flags.n = w_result[DATA_W-1];
        w_flags.z = (w_result == '0);
        w_flags.c = ~i_op[1] & w_sum[DATA_W];
        w_flags.v = ~i_op[1]
                  & ~(w_a_sh[DATA_W-1] ^ i_b[DATA_W-1] ^ i_op[0])
                  &  (w_a_sh[DATA_W-1] ^ w_sum[DATA_W-1]);
    end

    assign o_result = w_result;
    assign o_flags  = w_flags;

endmodule

// File: rtl/alu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// alu_rr_arbiter
// Shares one shift/ALU datapath between two issuing units. A round-robin
// arbiter accepts one request at a time, latches its operands, evaluates
// them in the datapath and returns result, flags and requester ID on a
// registered valid/ready response channel. At most one op is in flight,
// giving a peak rate of one op every three cycles.
//
// State table
//   state    | meaning
//   ST_IDLE  | waiting for a request; req_ready follows the grant
//   ST_EXEC  | datapath evaluates latched operands; response registered
//   ST_RESP  | rsp_valid high, payload frozen until rsp_ready
//
// Ports
//   clk          in   1        rising-edge clock
//   reset        in   1        asynchronous active-high reset
//   req_valid    in   2        request valid per requester
//   req_ready    out  2        request accept per requester (combinational)
//   req_a0/1     in   DATA_W   operand a, requester 0/1
//   req_b0/1     in   DATA_W   operand b, requester 0/1
//   req_op0/1    in   OPC_W    ALU opcode, requester 0/1
//   req_sh0/1    in   SHAMT_W  shift amount for a, requester 0/1
//   req_dir0/1   in   1        shift direction, requester 0/1
//   rsp_valid    out  1        response valid
//   rsp_ready    in   1        response accept
//   rsp_id       out  1        requester that issued this response
//   rsp_result   out  DATA_W   ALU result
//   rsp_flags    out  4        {N,Z,C,V}
//   busy         out  1        high whenever not in ST_IDLE
// ---------------------------------------------------------------------------
module alu_rr_arbiter
    import alu_rr_arbiter_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF,
    parameter int OPC_W   = OPC_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [DATA_W-1:0]  req_a0,
    input  logic [DATA_W-1:0]  req_a1,
    input  logic [DATA_W-1:0]  req_b0,
    input  logic [DATA_W-1:0]  req_b1,
    input  logic [OPC_W-1:0]   req_op0,
    input  logic [OPC_W-1:0]   req_op1,
    input  logic [SHAMT_W-1:0] req_sh0,
    input  logic [SHAMT_W-1:0] req_sh1,
    input  logic               req_dir0,
    input  logic               req_dir1,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [DATA_W-1:0]  rsp_result,
    output logic [3:0]         rsp_flags,
    output logic               busy
);

    logic [1:0]         r_state;
    logic               r_rr_last;

    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [OPC_W-1:0]   r_op;
    logic [SHAMT_W-1:0] r_sh;
    logic               r_dir;
    logic               r_id;

    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_result;
    logic [3:0]         r_rsp_flags;

    logic [1:0]         w_grant;
    logic               w_accept;
    logic               w_sel;
    logic [DATA_W-1:0]  w_dp_result;
    logic [3:0]         w_dp_flags;

    // ---------------- arbitration ----------------
    assign w_grant   = rr_pick(req_valid, r_rr_last);
    assign req_ready = (r_state == ST_IDLE) ? w_grant : 2'b00;

    // req_ready is one-hot or zero, so bit 1 directly names the winner.
    assign w_accept  = |(req_valid & req_ready);
    assign w_sel     = req_ready[1];

    // ---------------- datapath ----------------
    shift_alu_datapath #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W),
        .OPC_W   (OPC_W)
    ) u_datapath (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .i_sh     (r_sh),
        .i_dir    (r_dir),
        .o_result (w_dp_result),
        .o_flags  (w_dp_flags)
    );

    // ---------------- control FSM and registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rr_last    <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_sh         <= '0;
            r_dir        <= 1'b0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a       <= w_sel ? req_a1   : req_a0;
                        r_b       <= w_sel ? req_b1   : req_b0;
                        r_op      <= w_sel ? req_op1  : req_op0;
                        r_sh      <= w_sel ? req_sh1  : req_sh0;
                        r_dir     <= w_sel ? req_dir1 : req_dir0;
                        r_id      <= w_sel;
                        r_rr_last <= w_sel;
                        r_state   <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    r_rsp_result <= w_dp_result;
                    r_rsp_flags  <= w_dp_flags;
                    r_rsp_id     <= r_id;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= ST_RESP;
                end

                ST_RESP: begin
                    // Payload registers are left untouched so the last
                    // response stays visible after the handshake.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
module tb_alu_rr_arbiter;

    typedef struct {
        logic       id;
        logic [4:0] a;
        logic [4:0] b;
        logic [2:0] op;
        logic [1:0] sh;
        logic       dir;
        logic [4:0] res;
        logic [3:0] flg;
    } vec_t;

    typedef struct packed {
        logic       id;
        logic [4:0] res;
        logic [3:0] flg;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [4:0] req_a0, req_a1, req_b0, req_b1;
    logic [2:0] req_op0, req_op1;
    logic [1:0] req_sh0, req_sh1;
    logic       req_dir0, req_dir1;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [4:0] rsp_result;
    logic [3:0] rsp_flags;
    logic       busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    exp_t m_e;
    vec_t tbl[13];
    vec_t t4[4];

    alu_rr_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_sh0    (req_sh0),
        .req_sh1    (req_sh1),
        .req_dir0   (req_dir0),
        .req_dir1   (req_dir1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int id, input int a, input int b, input int op,
                                input int sh, input int dir, input int res, input int flg);
        vec_t v;
        v.id  = 1'(id);
        v.a   = 5'(a);
        v.b   = 5'(b);
        v.op  = 3'(op);
        v.sh  = 2'(sh);
        v.dir = 1'(dir);
        v.res = 5'(res);
        v.flg = 4'(flg);
        return v;
    endfunction

    // Response monitor: compares each handshaken response against the
    // oldest expectation in the scoreboard.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                m_e = sb.pop_front();
                check("rsp_id",     int'(rsp_id),     int'(m_e.id));
                check("rsp_result", int'(rsp_result), int'(m_e.res));
                check("rsp_flags",  int'(rsp_flags),  int'(m_e.flg));
            end
        end
    end

    task automatic drive(input vec_t v);
        if (v.id == 1'b0) begin
            req_a0 = v.a; req_b0 = v.b; req_op0 = v.op; req_sh0 = v.sh; req_dir0 = v.dir;
            req_valid[0] = 1'b1;
        end else begin
            req_a1 = v.a; req_b1 = v.b; req_op1 = v.op; req_sh1 = v.sh; req_dir1 = v.dir;
            req_valid[1] = 1'b1;
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_t t;
        t.id  = v.id;
        t.res = v.res;
        t.flg = v.flg;
        sb.push_back(t);
    endtask

    // Waits for the request of v.id to be accepted; returns just after the
    // accept edge with that requester's valid dropped.
    task automatic wait_accept(input vec_t v, input bit push);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[v.id]) got = 1'b1;
        end
        check("accept", int'(got), 1);
        if (got && push) push_exp(v);
        @(posedge clk); #1;
        req_valid[v.id] = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
        #1;
        check("drain", sb.size(), 0);
    endtask

    initial begin
        int k;
        int cnt[2];
        int r;

        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        req_a0 = '0; req_b0 = '0; req_op0 = '0; req_sh0 = '0; req_dir0 = 1'b0;
        req_a1 = '0; req_b1 = '0; req_op1 = '0; req_sh1 = '0; req_dir1 = 1'b0;

        //             id  a   b  op sh dir res  flags
        tbl[0]  = mk(0,  3,  2, 0, 1, 0,  8, 4'b0000);
        tbl[1]  = mk(1,  4,  4, 1, 0, 0,  0, 4'b0110);
        tbl[2]  = mk(0,  7,  5, 0, 1, 0, 19, 4'b1001);
        tbl[3]  = mk(1,  5,  3, 2, 2, 1,  1, 4'b0000);
        tbl[4]  = mk(0, 12, 10, 3, 0, 0, 14, 4'b0000);
        tbl[5]  = mk(1,  9,  9, 4, 0, 0,  0, 4'b0101);
        tbl[6]  = mk(0,  1,  0, 5, 0, 0,  0, 4'b0110);
        tbl[7]  = mk(1, 24,  1, 6, 0, 0,  0, 4'b0100);
        tbl[8]  = mk(0, 31,  1, 0, 0, 0,  0, 4'b0110);
        tbl[9]  = mk(1, 16,  1, 1, 0, 0, 15, 4'b0011);
        tbl[10] = mk(0,  3,  0, 0, 3, 0, 24, 4'b1000);
        tbl[11] = mk(1, 31,  0, 3, 3, 1,  3, 4'b0000);
        tbl[12] = mk(0,  5,  1, 1, 0, 0,  4, 4'b0010);

        t4[0] = mk(0, 5, 2, 0, 2, 1, 3, 4'b0000);
        t4[1] = tbl[1];
        t4[2] = tbl[2];
        t4[3] = tbl[5];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid",  int'(rsp_valid),  0);
        check("rst_rsp_id",     int'(rsp_id),     0);
        check("rst_rsp_result", int'(rsp_result), 0);
        check("rst_rsp_flags",  int'(rsp_flags),  0);
        check("rst_req_ready",  int'(req_ready),  0);
        check("rst_busy",       int'(busy),       0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Latency: EXEC cycle shows no response, RESP cycle does.
        drive(tbl[0]);
        wait_accept(tbl[0], 1'b1);
        drive(tbl[1]);
        @(negedge clk);
        check("t1_exec_rsp_valid", int'(rsp_valid), 0);
        check("t1_exec_busy",      int'(busy),      1);
        check("t1_exec_req_ready", int'(req_ready), 0);
        @(negedge clk);
        check("t1_resp_rsp_valid", int'(rsp_valid), 1);
        check("t1_resp_req_ready", int'(req_ready), 0);
        wait_accept(tbl[1], 1'b1);
        drain();

        // Table of single-requester operations
        for (int i = 2; i < 13; i++) begin
            drive(tbl[i]);
            wait_accept(tbl[i], 1'b1);
            drain();
        end

        // Response back-pressure: payload held, no new accept
        rsp_ready = 1'b0;
        drive(tbl[3]);
        wait_accept(tbl[3], 1'b1);
        drive(tbl[0]);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_rsp_valid",  int'(rsp_valid),  1);
            check("t5_rsp_result", int'(rsp_result), int'(tbl[3].res));
            check("t5_rsp_flags",  int'(rsp_flags),  int'(tbl[3].flg));
            check("t5_rsp_id",     int'(rsp_id),     1);
            check("t5_req_ready",  int'(req_ready),  0);
            check("t5_busy",       int'(busy),       1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_accept(tbl[0], 1'b1);
        drain();

        // Reset during EXEC drops the op; rr_last returns to favour req 0.
        drive(tbl[1]);
        wait_accept(tbl[1], 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_rsp_valid", int'(rsp_valid), 0);
        check("t6_rst_busy",      int'(busy),      0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_rsp", int'(rsp_valid), 0);
        end
        @(posedge clk); #1;

        // Both requesters valid back to back: grants alternate 0,1,0,1.
        drive(t4[0]);
        drive(t4[1]);
        k = 0;
        cnt[0] = 0;
        cnt[1] = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                check("t4_grant", int'(req_ready), (k % 2 == 0) ? 1 : 2);
                push_exp(t4[k]);
                r = req_ready[1] ? 1 : 0;
                @(posedge clk); #1;
                cnt[r]++;
                if (cnt[r] < 2) drive(t4[r + 2 * cnt[r]]);
                else req_valid[r] = 1'b0;
                k++;
            end
        end
        check("t4_count", k, 4);
        req_valid = 2'b00;
        drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
